// File: rtl/serial_payload_receiver.sv
// Captures DATA_W serial payload bits after a select pulse and holds the word on a valid/ready register.
// Optional trailing even-parity bit is enabled by defining PAYLOAD_PARITY_EN.
module serial_payload_receiver #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              din,
    input  logic              data_ready,
    output logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              overrun,
    output logic              parity_err
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef PAYLOAD_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word;
    logic              complete;
`ifdef PAYLOAD_PARITY_EN
    logic              perr_q, perr_d;
`endif

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[DATA_W-2:0], din};
        end else begin
            shifted = {din, shift_q[DATA_W-1:1]};
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        complete  = 1'b0;
        word      = shifted;
`ifdef PAYLOAD_PARITY_EN
        perr_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (sel) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                shift_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
`ifdef PAYLOAD_PARITY_EN
                    state_d = PARITY;
`else
                    state_d  = IDLE;
                    complete = 1'b1;
`endif
                end
            end
`ifdef PAYLOAD_PARITY_EN
            PARITY: begin
                // Word is already assembled; this edge only samples the parity bit.
                state_d = IDLE;
                word    = shift_q;
                if (^{shift_q, din}) begin
                    perr_d = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A word consumed on the completion edge frees the holding register for the new one.
        if (complete) begin
            if (!valid_q || data_ready) begin
                data_d  = word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PAYLOAD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_serial_payload_receiver.sv
// Scoreboard bench for serial_payload_receiver: frame-level reference model feeds a queue, monitor pops on new words.
// Two instances share the stimulus, one per bit order.
module tb_serial_payload_receiver;
`ifdef PAYLOAD_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       din = 1'b0;
    logic       data_ready = 1'b0;
    logic       busy, data_valid, overrun, parity_err;
    logic [7:0] data;
    logic       busy_l, valid_l, ovr_l, perr_l;
    logic [7:0] data_l;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ready = 0;

    logic [15:0] exp_q[$];
    int          exp_ovr = 0, exp_perr = 0, obs_ovr = 0, obs_perr = 0, words_seen = 0;

    serial_payload_receiver #(.DATA_W(8), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .sel(sel), .din(din), .data_ready(data_ready),
        .busy(busy), .data(data), .data_valid(data_valid), .overrun(overrun), .parity_err(parity_err)
    );

    serial_payload_receiver #(.DATA_W(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .sel(sel), .din(din), .data_ready(data_ready),
        .busy(busy_l), .data(data_l), .data_valid(valid_l), .overrun(ovr_l), .parity_err(perr_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are bit lists; the holding register is a single flag.
    bit m_cap = 0;
    bit m_valid = 0;
    bit m_bits[$];
    always @(posedge clk) begin
        bit         hs, fin, par;
        logic [7:0] wm, wl;
        fin = 0;
        if (rst) begin
            m_cap = 0;
            m_valid = 0;
            m_bits.delete();
            exp_q.delete();
        end else begin
            hs = m_valid && data_ready;
            if (m_cap) begin
                m_bits.push_back(din);
                if (m_bits.size() == FRAME) begin
                    m_cap = 0;
                    fin = 1;
                end
            end else if (sel) begin
                m_cap = 1;
                m_bits.delete();
            end
            if (fin) begin
                wm = 8'h00;
                wl = 8'h00;
                par = 0;
                for (int i = 0; i < 8; i++) begin
                    wm = {wm[6:0], m_bits[i]};
                    wl[i] = m_bits[i];
                end
                for (int i = 0; i < FRAME; i++) par = par ^ m_bits[i];
                if (FRAME == 9 && par) begin
                    exp_perr++;
                    if (hs) m_valid = 0;
                end else if (!m_valid || hs) begin
                    exp_q.push_back({wm, wl});
                    m_valid = 1;
                end else begin
                    exp_ovr++;
                end
            end else if (hs) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: a word is new when valid is seen and the previous one was handed over (or none yet).
    bit fresh = 1;
    bit hs_pend = 0;
    int busy_run = 0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            fresh = 1;
            hs_pend = 0;
            busy_run = 0;
        end else begin
            if (hs_pend) fresh = 1;
            if (data_valid && fresh) begin
                fresh = 0;
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'h0, data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word_msb", {24'h0, data}, {24'h0, e[15:8]});
                    check("word_lsb", {24'h0, data_l}, {24'h0, e[7:0]});
                end
            end
            hs_pend = data_valid && data_ready;
            if (overrun) obs_ovr++;
            if (parity_err) obs_perr++;
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, FRAME);
                busy_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) data_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] w, input int stray_at, input bit bad_par, input bit rdy_last);
        sel = 1;
        tick();
        sel = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i < 8) din = w[7-i];
            else din = (^w) ^ bad_par;
            sel = (i == stray_at);
            if (rdy_last && i == FRAME - 1) data_ready = 1;
            tick();
        end
        sel = 0;
        if (rdy_last) data_ready = 0;
    endtask

    task automatic consume();
        data_ready = 1;
        tick();
        data_ready = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {24'h0, data}, 32'h0);
        check({tag, "_data_lsb"}, {24'h0, data_l}, 32'h0);
        check({tag, "_valid"}, {31'h0, data_valid}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
        check({tag, "_parity_err"}, {31'h0, parity_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        tick();
        tick();
        rst = 0;
        check_all_zero("reset");

        // Capture with both bit orders.
        send_frame(8'hB2, -1, 0, 0);
        check("cap_valid", {31'h0, data_valid}, 32'h1);
        check("cap_data_msb", {24'h0, data}, 32'hB2);
        check("cap_data_lsb", {24'h0, data_l}, 32'h4D);

        // Held word blocks the second frame.
        send_frame(8'h0F, -1, 0, 0);
        check("ovr_pulse", {31'h0, overrun}, 32'h1);
        check("ovr_data_kept", {24'h0, data}, 32'hB2);
        tick();
        check("ovr_one_cycle", {31'h0, overrun}, 32'h0);
        consume();

        // Consumer takes the old word on the completion edge.
        send_frame(8'hB2, -1, 0, 0);
        send_frame(8'h0F, -1, 0, 1);
        check("swap_data", {24'h0, data}, 32'h0F);
        check("swap_no_ovr", {31'h0, overrun}, 32'h0);
        consume();

        // Stray sel during capture and on the final bit.
        send_frame(8'hB2, 3, 0, 0);
        check("stray_data", {24'h0, data}, 32'hB2);
        check("stray_no_restart", {31'h0, busy}, 32'h0);
        consume();
        send_frame(8'h3C, FRAME - 1, 0, 0);
        tick();
        check("last_bit_sel_ignored", {31'h0, busy}, 32'h0);
        consume();
        for (int i = 0; i < 16; i++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
        check("no_sel_no_word", {31'h0, data_valid}, 32'h0);

        // Reset mid-capture with a word held.
        send_frame(8'h3C, -1, 0, 0);
        sel = 1;
        tick();
        sel = 0;
        for (int i = 0; i < 5; i++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1;
        tick();
        rst = 0;
        check_all_zero("midrst");
        send_frame(8'hA5, -1, 0, 0);
        check("after_rst_data", {24'h0, data}, 32'hA5);
        consume();

`ifdef PAYLOAD_PARITY_EN
        send_frame(8'hB2, -1, 0, 0);
        check("par_ok_valid", {31'h0, data_valid}, 32'h1);
        check("par_ok_data", {24'h0, data}, 32'hB2);
        consume();
        send_frame(8'hB2, -1, 1, 0);
        check("par_bad_pulse", {31'h0, parity_err}, 32'h1);
        check("par_bad_no_valid", {31'h0, data_valid}, 32'h0);
        check("par_bad_no_ovr", {31'h0, overrun}, 32'h0);
        tick();
        check("par_bad_one_cycle", {31'h0, parity_err}, 32'h0);
`endif

        // Randomized frames, gaps and backpressure.
        rand_ready = 1;
        for (int f = 0; f < 60; f++) begin
            send_frame(8'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 7) == 0), 0);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                din = 1'($urandom_range(0, 1));
                tick();
            end
        end
        rand_ready = 0;
        data_ready = 1;
        repeat (4) tick();
        data_ready = 0;

        check("queue_drained", exp_q.size(), 0);
        check("overrun_count", obs_ovr, exp_ovr);
        check("parity_err_count", obs_perr, exp_perr);
        check("words_nonzero", {31'h0, (words_seen > 10)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
